// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
//
// Memory-mapped UART transmitter (8N1, LSB first) with a small TX byte FIFO.
//
// Register map (word address bits [1:0]):
//   0 TXDATA  : write-only, pushes wdata[7:0] when byte lane 0 is enabled;
//               reads 0
//   1 STATUS  : bit0 busy, bit1 full, bit2 empty, bit3 overflow (sticky,
//               write 1 to clear), bits[8:4] FIFO count; other bits 0
//   2 DIVISOR : [15:0] bit period in clocks, 0 behaves as 1
//   3 CTRL    : bit0 tx_en (read/write), bit1 flush (write 1, reads 0)
//
// Ports:
//   i_clk             : single rising-edge clock
//   i_rst             : asynchronous active-high reset
//   in_sel            : bus addresses this block (decoded upstream)
//   in_mem_addr       : word address, [1:0] select the register
//   in_mem_rw_mode    : 1 = write, 0 = read
//   in_mem_write_data : write data
//   in_mem_byte_en    : write byte lanes
//   out_mem_data      : combinational read data, 0 unless selected for read
//   tx                : registered serial line, idle high
//   fsm_state         : current transmitter state (IDLE=0 START=1 DATA=2
//                       STOP=3), observation only
//
// Bus handshake: there is no valid/ready pair on this bus. A write is
// "valid" when in_sel && in_mem_rw_mode at a rising edge, and the block is
// always ready, so every such write completes in that cycle. A read is
// purely combinational in the same cycle and has no side effects.
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        in_sel,
  input  logic [9:0]  in_mem_addr,
  input  logic        in_mem_rw_mode,
  input  logic [31:0] in_mem_write_data,
  input  logic [3:0]  in_mem_byte_en,
  output logic [31:0] out_mem_data,
  output logic        tx,
  output logic [1:0]  fsm_state
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] ADDR_TXDATA  = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_DIVISOR = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state;
  logic [7:0]      shift_reg;
  logic [15:0]     baud_cnt;
  logic [15:0]     bit_len;     // period of the bit currently on the line
  logic [2:0]      bit_cnt;

  logic [15:0]     divisor;
  logic            tx_en;
  logic            overflow;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  // Bits of the bus that this block never looks at.
  logic unused_bits;
  assign unused_bits = ^{in_mem_addr[9:2], in_mem_write_data[31:16],
                         in_mem_byte_en[3:2]};

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic       wr_cycle;
  logic [1:0] reg_sel;
  logic       push_req;
  logic       flush_req;
  logic       ovf_clr;
  logic       ctrl_wr;

  assign wr_cycle  = in_sel && in_mem_rw_mode;
  assign reg_sel   = in_mem_addr[1:0];
  assign push_req  = wr_cycle && (reg_sel == ADDR_TXDATA) && in_mem_byte_en[0];
  assign ctrl_wr   = wr_cycle && (reg_sel == ADDR_CTRL) && in_mem_byte_en[0];
  assign flush_req = ctrl_wr && in_mem_write_data[1];
  assign ovf_clr   = wr_cycle && (reg_sel == ADDR_STATUS) && in_mem_byte_en[0]
                     && in_mem_write_data[3];

  // ---------------------------------------------------------------------------
  // FIFO status and pop decision
  // ---------------------------------------------------------------------------
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_avail;
  logic        bit_end;
  logic        pop;
  logic        push_ok;
  logic        ovf_set;
  logic [15:0] d_eff;
  logic [7:0]  rd_data;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  // A flush in the same cycle discards the head byte instead of sending it.
  assign fifo_avail = !fifo_empty && !flush_req;
  assign bit_end    = (baud_cnt == (bit_len - 16'd1));
  assign d_eff      = (divisor == 16'd0) ? 16'd1 : divisor;
  assign rd_data    = fifo_mem[rd_ptr];

  // A new frame is started from IDLE, or back to back from the last cycle
  // of a stop bit so there is no idle gap between frames.
  assign pop = tx_en && fifo_avail &&
               ((state == IDLE) || ((state == STOP) && bit_end));

  // A push to a full FIFO still fits when the head is popped that cycle.
  // After a flush the FIFO is empty, so the push always fits.
  assign push_ok = push_req && (flush_req || !fifo_full || pop);
  assign ovf_set = push_req && !push_ok;

  // ---------------------------------------------------------------------------
  // FIFO pointers and count
  // ---------------------------------------------------------------------------
  logic [PW-1:0] wr_idx;
  assign wr_idx = flush_req ? '0 : wr_ptr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_req) begin
      // The flush empties the FIFO first; a same-cycle push lands after it.
      rd_ptr <= '0;
      wr_ptr <= push_ok ? PW'(1) : '0;
      count  <= push_ok ? CW'(1) : '0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  // Storage has no reset; occupancy is tracked entirely by the pointers.
  always_ff @(posedge i_clk) begin
    if (push_ok) fifo_mem[wr_idx] <= in_mem_write_data[7:0];
  end

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      divisor  <= DIV_RESET;
      tx_en    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_cycle && (reg_sel == ADDR_DIVISOR)) begin
        if (in_mem_byte_en[0]) divisor[7:0]  <= in_mem_write_data[7:0];
        if (in_mem_byte_en[1]) divisor[15:8] <= in_mem_write_data[15:8];
      end
      if (ctrl_wr) tx_en <= in_mem_write_data[0];
      // Set has priority over a same-cycle clear.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter FSM
  // bit_len is sampled from DIVISOR at each bit boundary, so a DIVISOR write
  // never shortens or stretches the bit already on the line.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      shift_reg <= 8'h00;
      baud_cnt  <= 16'd0;
      bit_len   <= 16'd1;
      bit_cnt   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= 16'd0;
          bit_cnt  <= 3'd0;
          if (pop) begin
            shift_reg <= rd_data;
            bit_len   <= d_eff;
            tx        <= 1'b0;
            state     <= START;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            bit_len  <= d_eff;
            bit_cnt  <= 3'd0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            bit_len  <= d_eff;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            bit_len  <= d_eff;
            bit_cnt  <= 3'd0;
            if (pop) begin
              shift_reg <= rd_data;
              tx        <= 1'b0;
              state     <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [4:0]  count5;
  logic [31:0] status_word;

  always_comb begin
    count5      = 5'(count);
    status_word = {23'h0, count5, overflow, fifo_empty, fifo_full,
                   (state != IDLE)};
  end

  always_comb begin
    out_mem_data = 32'h0;
    if (in_sel && !in_mem_rw_mode) begin
      case (reg_sel)
        ADDR_TXDATA:  out_mem_data = 32'h0;
        ADDR_STATUS:  out_mem_data = status_word;
        ADDR_DIVISOR: out_mem_data = {16'h0, divisor};
        ADDR_CTRL:    out_mem_data = {31'h0, tx_en};
        default:      out_mem_data = 32'h0;
      endcase
    end
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning TX byte FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter DIV_RESET, default 16'd434, meaning reset value of the DIVISOR register.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port i_clk, input, 1, meaning the single rising-edge clock.
REQ-005 SHALL have port i_rst, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port in_sel, input, 1, meaning the data bus addresses this block (decoded upstream).
REQ-007 SHALL have port in_mem_addr, input, 10, meaning word address, where bits [1:0] select the register.
REQ-008 SHALL have port in_mem_rw_mode, input, 1, meaning 1=write and 0=read.
REQ-009 SHALL have port in_mem_write_data, input, 32, meaning write data.
REQ-010 SHALL have port in_mem_byte_en, input, 4, meaning write byte lanes.
REQ-011 SHALL have port out_mem_data, output, 32, meaning read data, combinational and same-cycle.
REQ-012 SHALL have port tx, output, 1, meaning the registered serial line, idle high.

Function
REQ-013 SHALL map the registers as follows: 0 TXDATA (write-only, reads 0); 1 STATUS (read-only except bit3); 2 DIVISOR [15:0] (read/write); 3 CTRL (bit0 tx_en read/write, bit1 flush write-1 and reads 0).
REQ-014 SHALL define STATUS as: bit0 busy (state!=IDLE); bit1 full; bit2 empty; bit3 overflow (sticky); bits[8:4] count; all other bits 0.
REQ-015 SHALL drive out_mem_data to 0 when in_sel=0 or in_mem_rw_mode=1.
REQ-016 SHALL take writes at the rising edge only when in_sel=1 and in_mem_rw_mode=1.
REQ-017 SHALL push in_mem_write_data[7:0] on a TXDATA write only if in_mem_byte_en[0]=1.
REQ-018 SHALL write DIVISOR bytes per in_mem_byte_en[1:0], ignoring lanes 2 and 3.
REQ-019 SHALL update CTRL only when in_mem_byte_en[0]=1.
REQ-020 SHALL drop a push to a full FIFO, leave the FIFO unchanged, and set overflow; a push to a full FIFO in the same cycle as a pop SHALL be accepted.
REQ-021 SHALL clear overflow on a STATUS write with in_mem_write_data[3]=1 and byte_en[0]=1; a set event in the same cycle SHALL win.
REQ-022 SHALL empty the FIFO on a flush; a same-cycle push SHALL land after the flush, leaving count=1; a frame in progress SHALL complete.
REQ-023 SHALL implement FSM states IDLE, START, DATA, STOP with bit period D = max(DIVISOR,1) cycles.
REQ-024 In IDLE with tx_en=1 and FIFO non-empty, SHALL pop at the edge, load the shift register, enter START, and set tx<=0 at that same edge.
REQ-025 SHALL hold START for D cycles, then DATA for 8 bits LSB-first at D cycles each, then STOP (tx=1) for D cycles, for a frame of 10*D cycles.
REQ-026 At the end of STOP, SHALL pop and go directly to START if tx_en=1 and the FIFO is non-empty (no idle gap); otherwise it SHALL go to IDLE.
REQ-027 SHALL apply a DIVISOR change at the next bit boundary only, never truncating or stretching the current bit.
REQ-028 On tx_en cleared mid-frame, SHALL complete the current frame and start no new one.
REQ-029 SHALL implement the FIFO as circular read/write pointers with wrap-around, plus a count of width log2(FIFO_DEPTH)+1.

Reset
REQ-030 On reset assertion, including mid-frame, SHALL immediately force tx=1, state=IDLE, FIFO empty (count 0), overflow=0, tx_en=0, DIVISOR=DIV_RESET, and baud and bit counters to 0.
REQ-031 SHALL have, after reset, out_mem_data for a STATUS read = 32'h0000_0004 (empty only).

Verification
REQ-032 SHALL cover: DIVISOR=4, tx_en=1, write TXDATA=8'hA5 -> tx low for 4 cycles starting at the edge after the write, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high; busy high for 40 cycles.
REQ-033 SHALL cover: tx_en=0, five TXDATA writes (depth 4) -> STATUS=32'h0000_004A (count 4, full, overflow); a STATUS write of 8 -> 32'h0000_0042.
REQ-034 SHALL cover: DIVISOR=2, two bytes queued, tx_en=1 -> two frames of 20 cycles each, with no idle cycle between the stop bit and the second start bit.
REQ-035 SHALL cover: mid-frame CTRL write of 3 (flush plus enable) with 3 bytes queued -> the current frame completes, count=0, and tx stays high afterward.
REQ-036 SHALL cover: i_rst asserted during DATA bit 3 -> tx=1 and STATUS=32'h0000_0004 without waiting for a clock edge, and DIVISOR reads 434.
REQ-037 SHALL cover: DIVISOR=0 -> D=1, frame lasts 10 cycles.
